// File: rtl/io_port_pkg.sv
// Shared types and constants for the CPU output-port serial transmitter.
package io_port_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int DATA_BITS      = 8;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/outport_serial_tx_sync_fifo.sv
// Synchronous FIFO with a separate occupancy counter; pushes while full are
// dropped and reported on the drop strobe, judged before any same-cycle pop.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_s, pop_ok_s;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == {CW{1'b0}});
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign drop     = push & full;

    // Next pointer and occupancy values.
    always_comb begin
        push_ok_s = push & ~full;
        pop_ok_s  = pop & ~empty;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + CW'(push_ok_s) - CW'(pop_ok_s);
    end

    // Pointer and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless once the pointers reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/outport_serial_tx.sv
// Queues CPU OutPort words and sends each as four 8N1 bytes, LSB byte first.
module outport_serial_tx
    import io_port_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          out_wr,
    input  logic [31:0]                   out_data,
    input  logic                          clr_ovf,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          word_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_full,
    output logic                          overflow
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              word_done_q, word_done_d;
    logic              overflow_q, overflow_d;
    logic              pop_s, empty_s, drop_s, bit_last_s;
    logic [31:0]       head_s;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (out_wr),
        .push_data (out_data),
        .pop       (pop_s),
        .pop_data  (head_s),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (empty_s),
        .drop      (drop_s)
    );

    assign bit_last_s = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // Frame sequencing; line outputs follow the state one cycle later.
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        byte_idx_d  = byte_idx_q;
        shift_d     = shift_q;
        pop_s       = 1'b0;
        done_d      = 1'b0;
        tx_d        = 1'b1;
        busy_d      = (state_q != IDLE);
        word_done_d = done_q;
        if (bit_last_s) begin
            clk_cnt_d = {CNT_W{1'b0}};
        end else begin
            clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
        case (state_q)
            IDLE: begin
                tx_d      = 1'b1;
                clk_cnt_d = {CNT_W{1'b0}};
                if (!empty_s) begin
                    pop_s      = 1'b1;
                    shift_d    = head_s;
                    byte_idx_d = 2'd0;
                    state_d    = START;
                end else begin
                    state_d    = IDLE;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_last_s) begin
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    state_d   = START;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (bit_last_s) begin
                    shift_d = {1'b0, shift_q[31:1]};
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_last_s) begin
                    if (byte_idx_q == 2'(BYTES_PER_WORD - 1)) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = START;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
        // A dropped write outranks a same-cycle clear.
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            clk_cnt_q   <= {CNT_W{1'b0}};
            bit_idx_q   <= 3'd0;
            byte_idx_q  <= 2'd0;
            shift_q     <= 32'd0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            word_done_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            byte_idx_q  <= byte_idx_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            word_done_q <= word_done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign tx        = tx_q;
    assign tx_busy   = busy_q;
    assign word_done = word_done_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_outport_serial_tx.sv
// Directed bench for outport_serial_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_outport_serial_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        out_wr;
    logic [31:0] out_data;
    logic        clr_ovf;
    logic        tx;
    logic        tx_busy;
    logic        word_done;
    logic [2:0]  fifo_count;
    logic        fifo_full;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    outport_serial_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .out_wr     (out_wr),
        .out_data   (out_data),
        .clr_ovf    (clr_ovf),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .word_done  (word_done),
        .fifo_count (fifo_count),
        .fifo_full  (fifo_full),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] d);
        out_wr   = 1'b1;
        out_data = d;
        @(negedge clk);
        out_wr   = 1'b0;
    endtask

    // Waits for a start bit, then samples all 40 bit centres of one word.
    task automatic recv(input logic [31:0] exp, input string tag, input int exp_wait);
        int          waited = 0;
        bit          got = 1'b0;
        bit          frame_ok = 1'b1;
        logic [31:0] w = 32'd0;
        while (waited < 400 && !got) begin
            @(negedge clk);
            waited++;
            if (tx === 1'b0) got = 1'b1;
        end
        check({tag, "_start"}, 32'(tx), 32'd0);
        if (!got) return;
        if (exp_wait >= 0) check({tag, "_gap"}, 32'(waited), 32'(exp_wait));
        for (int off = 1; off <= 40 * CPB; off++) begin
            @(negedge clk);
            if (off % CPB == CPB / 2) begin
                int j = off / CPB;
                int b = j % 10;
                if (b == 0) frame_ok &= (tx === 1'b0);
                else if (b == 9) frame_ok &= (tx === 1'b1);
                else w[(j / 10) * 8 + b - 1] = tx;
            end
            if (off == 20 * CPB) check({tag, "_busy"}, 32'(tx_busy), 32'd1);
            if (off == 40 * CPB - 1) check({tag, "_done_early"}, 32'(word_done), 32'd0);
        end
        check({tag, "_done"}, 32'(word_done), 32'd1);
        check({tag, "_idle_tx"}, 32'(tx), 32'd1);
        check({tag, "_frame"}, 32'(frame_ok), 32'd1);
        check({tag, "_word"}, w, exp);
    endtask

    initial begin
        int k;
        bit quiet;
        reset    = 1'b1;
        out_wr   = 1'b0;
        out_data = 32'd0;
        clr_ovf  = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx",    32'(tx),         32'd1);
        check("rst_busy",  32'(tx_busy),    32'd0);
        check("rst_done",  32'(word_done),  32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_full",  32'(fifo_full),  32'd0);
        check("rst_ovf",   32'(overflow),   32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single word: start bit two edges after the write.
        wr(32'h12345678);
        recv(32'h12345678, "single", 2);
        check("single_busy_after", 32'(tx_busy), 32'd0);
        @(negedge clk);
        check("single_done_pulse", 32'(word_done), 32'd0);
        repeat (5) @(negedge clk);

        // Back-to-back writes; the second coincides with the first pop.
        fork
            begin
                out_wr = 1'b1; out_data = 32'hA0000001; @(negedge clk);
                check("b2b_cnt1", 32'(fifo_count), 32'd1);
                out_data = 32'hA0000002; @(negedge clk);
                check("b2b_cnt2", 32'(fifo_count), 32'd1);
                out_data = 32'hA0000003; @(negedge clk);
                check("b2b_cnt3", 32'(fifo_count), 32'd2);
                out_data = 32'hA0000004; @(negedge clk);
                check("b2b_cnt4", 32'(fifo_count), 32'd3);
                out_wr = 1'b0;
            end
            begin
                recv(32'hA0000001, "b2b_w1", 3);
                recv(32'hA0000002, "b2b_w2", 1);
                recv(32'hA0000003, "b2b_w3", 1);
                recv(32'hA0000004, "b2b_w4", 1);
            end
        join
        check("b2b_ovf", 32'(overflow), 32'd0);
        repeat (5) @(negedge clk);

        // Six writes: one popped, four fill the FIFO, the sixth is dropped.
        fork
            begin
                out_wr = 1'b1;
                out_data = 32'hB0000001; @(negedge clk);
                out_data = 32'hB0000002; @(negedge clk);
                out_data = 32'hB0000003; @(negedge clk);
                out_data = 32'hB0000004; @(negedge clk);
                out_data = 32'hB0000005; @(negedge clk);
                check("ovf_cnt_full", 32'(fifo_count), 32'd4);
                check("ovf_full_pre", 32'(fifo_full),  32'd1);
                check("ovf_flag_pre", 32'(overflow),   32'd0);
                out_data = 32'hB0000006; @(negedge clk);
                out_wr = 1'b0;
                check("ovf_flag_set", 32'(overflow),   32'd1);
                check("ovf_cnt_kept", 32'(fifo_count), 32'd4);
                clr_ovf = 1'b1; @(negedge clk); clr_ovf = 1'b0;
                check("ovf_clear", 32'(overflow), 32'd0);
                out_wr = 1'b1; out_data = 32'hB0000007; clr_ovf = 1'b1;
                @(negedge clk);
                out_wr = 1'b0; clr_ovf = 1'b0;
                check("ovf_clash", 32'(overflow), 32'd1);
                clr_ovf = 1'b1; @(negedge clk); clr_ovf = 1'b0;
                check("ovf_clear2", 32'(overflow), 32'd0);
            end
            begin
                recv(32'hB0000001, "ovf_w1", 3);
                recv(32'hB0000002, "ovf_w2", 1);
                recv(32'hB0000003, "ovf_w3", 1);
                recv(32'hB0000004, "ovf_w4", 1);
                recv(32'hB0000005, "ovf_w5", 1);
                quiet = 1'b1;
                repeat (60) begin
                    @(negedge clk);
                    quiet &= (tx === 1'b1);
                end
                check("ovf_no_w6", 32'(quiet), 32'd1);
            end
        join

        // Push during pop: 0x0000FFFF follows as the next word.
        fork
            begin
                out_wr = 1'b1; out_data = 32'h11111111; @(negedge clk);
                out_data = 32'h0000FFFF; @(negedge clk);
                out_wr = 1'b0;
                check("pp_count", 32'(fifo_count), 32'd1);
            end
            begin
                recv(32'h11111111, "pp_w1", 3);
                recv(32'h0000FFFF, "pp_w2", 1);
            end
        join
        repeat (5) @(negedge clk);

        // Reset asserted during data bit 3 of byte 1 (0x56 bit 3 is 0).
        out_wr = 1'b1; out_data = 32'h12345678; @(negedge clk);
        out_data = 32'hCAFEBABE; @(negedge clk);
        out_wr = 1'b0;
        k = 0;
        while (tx !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("mid_fall", 32'(tx), 32'd0);
        repeat (14 * CPB + CPB / 2) @(negedge clk);
        check("mid_tx_pre",    32'(tx),         32'd0);
        check("mid_busy_pre",  32'(tx_busy),    32'd1);
        check("mid_count_pre", 32'(fifo_count), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_tx_rst",    32'(tx),         32'd1);
        check("mid_busy_rst",  32'(tx_busy),    32'd0);
        check("mid_count_rst", 32'(fifo_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        quiet = 1'b1;
        repeat (100) begin
            @(negedge clk);
            quiet &= (tx === 1'b1) && (tx_busy === 1'b0) && (fifo_count === 3'd0);
        end
        check("mid_quiet", 32'(quiet), 32'd1);
        wr(32'h0F0F00FF);
        recv(32'h0F0F00FF, "post_rst", 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
